// File: rtl/noc_leaf_injector.sv
// Credit-based injection stage from a client packet stream into a NoC leaf.
// Round-robin VC selection among VCs holding credit; illegal dests dropped.
module noc_leaf_injector #(
    parameter int N             = 32,
    parameter int A_W           = 6,
    parameter int D_W           = 32,
    parameter int VC_W          = 8,
    parameter int VC_FIFO_DEPTH = 4,
    parameter int CNT_W         = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_W-1:0]       in_dest,
    input  logic [D_W-1:0]       in_data,
    output logic [VC_W-1:0]      vc_target,
    output logic [A_W+D_W-1:0]   packet,
    input  logic [VC_W-1:0]      vc_credit_gnt,
    output logic [CNT_W-1:0]     sent_count,
    output logic [CNT_W-1:0]     drop_count,
    output logic                 credit_err
);

    localparam int CR_W  = $clog2(VC_FIFO_DEPTH);
    localparam int PTR_W = $clog2(VC_W);
    localparam logic [CR_W-1:0]  CR_MAX  = CR_W'(VC_FIFO_DEPTH - 1);
    localparam logic [A_W:0]     N_LIM   = (A_W + 1)'(N);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [PTR_W:0]   VC_LIM  = (PTR_W + 1)'(VC_W);

    logic [CR_W-1:0]      r_credit [VC_W];
    logic [PTR_W-1:0]     r_ptr;
    logic [VC_W-1:0]      r_vc;
    logic [A_W+D_W-1:0]   r_pkt;
    logic [CNT_W-1:0]     r_sent;
    logic [CNT_W-1:0]     r_drop;
    logic                 r_err;

    logic [VC_W-1:0]      w_has;
    logic [VC_W-1:0]      w_dec;
    logic [VC_W-1:0]      w_over;
    logic [PTR_W-1:0]     w_sel;
    logic [PTR_W-1:0]     w_sel_nxt;
    logic [PTR_W:0]       w_idx;
    logic                 w_found;
    logic                 w_acc;
    logic                 w_legal;
    logic                 w_emit;
    logic                 w_drop;

    always_comb begin
        for (int v = 0; v < VC_W; v++) begin
            w_has[v] = (r_credit[v] != '0);
        end
    end

    assign in_ready = |w_has;

    // Rotating priority scan starting at r_ptr.
    always_comb begin
        w_sel   = r_ptr;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < VC_W; i++) begin
            w_idx = {1'b0, r_ptr} + (PTR_W + 1)'(i);
            if (w_idx >= VC_LIM) begin
                w_idx = w_idx - VC_LIM;
            end
            if (!w_found && w_has[w_idx[PTR_W-1:0]]) begin
                w_sel   = w_idx[PTR_W-1:0];
                w_found = 1'b1;
            end
        end
    end

    assign w_sel_nxt = (w_sel == PTR_W'(VC_W - 1)) ? '0 : w_sel + 1'b1;

    assign w_acc   = in_valid && in_ready;
    assign w_legal = ({1'b0, in_dest} < N_LIM);
    assign w_emit  = w_acc && w_legal;
    assign w_drop  = w_acc && !w_legal;

    always_comb begin
        for (int v = 0; v < VC_W; v++) begin
            w_dec[v]  = w_emit && (w_sel == PTR_W'(v));
            w_over[v] = vc_credit_gnt[v] && !w_dec[v] &&
                        (r_credit[v] == CR_MAX);
        end
    end

    // A return and a decrement on the same VC cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < VC_W; v++) begin
                r_credit[v] <= CR_MAX;
            end
        end else begin
            for (int v = 0; v < VC_W; v++) begin
                if (w_dec[v] && !vc_credit_gnt[v]) begin
                    r_credit[v] <= r_credit[v] - 1'b1;
                end else if (!w_dec[v] && vc_credit_gnt[v] &&
                             r_credit[v] != CR_MAX) begin
                    r_credit[v] <= r_credit[v] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr  <= '0;
            r_vc   <= '0;
            r_pkt  <= '0;
            r_sent <= '0;
            r_drop <= '0;
            r_err  <= 1'b0;
        end else begin
            r_vc  <= '0;
            r_pkt <= '0;
            if (w_emit) begin
                r_ptr <= w_sel_nxt;
                r_vc  <= VC_W'(1) << w_sel;
                r_pkt <= {in_dest, in_data};
                if (r_sent != CNT_MAX) begin
                    r_sent <= r_sent + 1'b1;
                end
            end
            if (w_drop && r_drop != CNT_MAX) begin
                r_drop <= r_drop + 1'b1;
            end
            if (|w_over) begin
                r_err <= 1'b1;
            end
        end
    end

    assign vc_target  = r_vc;
    assign packet     = r_pkt;
    assign sent_count = r_sent;
    assign drop_count = r_drop;
    assign credit_err = r_err;

endmodule

// File: tb/tb_noc_leaf_injector.sv
// Self-checking bench for noc_leaf_injector: vector table, directed
// corner sequences and a randomized run against a behavioural model.
module tb_noc_leaf_injector;

    localparam int N     = 32;
    localparam int A_W   = 6;
    localparam int D_W   = 32;
    localparam int VC_W  = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
    localparam int P_W   = A_W + D_W;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [A_W-1:0]   in_dest;
    logic [D_W-1:0]   in_data;
    logic [VC_W-1:0]  vc_target;
    logic [P_W-1:0]   packet;
    logic [VC_W-1:0]  vc_credit_gnt;
    logic [CNT_W-1:0] sent_count;
    logic [CNT_W-1:0] drop_count;
    logic             credit_err;

    int checks;
    int errors;

    noc_leaf_injector #(
        .N(N), .A_W(A_W), .D_W(D_W), .VC_W(VC_W),
        .VC_FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_dest(in_dest),
        .in_data(in_data),
        .vc_target(vc_target),
        .packet(packet),
        .vc_credit_gnt(vc_credit_gnt),
        .sent_count(sent_count),
        .drop_count(drop_count),
        .credit_err(credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            v;
        logic [A_W-1:0]  d;
        logic [D_W-1:0]  data;
        logic [VC_W-1:0] gnt;
        logic            rdy;
        logic [VC_W-1:0] vc;
        logic [P_W-1:0]  pkt;
        int              sent;
        int              drop;
        logic            err;
    } vec_t;

    vec_t tv[9];

    // Behavioural model: credit pool per VC, a pointer, and counters.
    int              m_cr[VC_W];
    int              m_ptr;
    int              m_sent;
    int              m_drop;
    logic            m_err;
    logic [VC_W-1:0] m_vc;
    logic [P_W-1:0]  m_pkt;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int v = 0; v < VC_W; v++) m_cr[v] = DEPTH - 1;
        m_ptr  = 0;
        m_sent = 0;
        m_drop = 0;
        m_err  = 1'b0;
        m_vc   = '0;
        m_pkt  = '0;
    endtask

    function automatic logic m_ready();
        int total;
        total = 0;
        for (int v = 0; v < VC_W; v++) total += m_cr[v];
        return total > 0;
    endfunction

    task automatic m_step(logic v, logic [A_W-1:0] d,
                          logic [D_W-1:0] data, logic [VC_W-1:0] g);
        int sel;
        m_vc  = '0;
        m_pkt = '0;
        if (v && m_ready()) begin
            if (int'(d) < N) begin
                sel = -1;
                for (int k = 0; k < VC_W && sel < 0; k++) begin
                    if (m_cr[(m_ptr + k) % VC_W] > 0) sel = (m_ptr + k) % VC_W;
                end
                m_vc  = VC_W'(1) << sel;
                m_pkt = {d, data};
                m_cr[sel]--;
                m_ptr = (sel + 1) % VC_W;
                if (m_sent < (1 << CNT_W) - 1) m_sent++;
            end else begin
                if (m_drop < (1 << CNT_W) - 1) m_drop++;
            end
        end
        for (int k = 0; k < VC_W; k++) begin
            if (g[k]) begin
                if (m_cr[k] == DEPTH - 1) m_err = 1'b1;
                else m_cr[k]++;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic v, logic [A_W-1:0] d,
                         logic [D_W-1:0] data, logic [VC_W-1:0] g);
        in_valid      = v;
        in_dest       = d;
        in_data       = data;
        vc_credit_gnt = g;
    endtask

    task automatic do_reset();
        drive(1'b0, '0, '0, '0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        m_reset();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(1'b0, '0, '0, '0);
        m_reset();

        tv[0] = '{1'b1, 6'd5,  32'hA5A5A5A5, 8'h00, 1'b1, 8'h01,
                  {6'd5, 32'hA5A5A5A5}, 1, 0, 1'b0};
        tv[1] = '{1'b1, 6'd40, 32'h00001234, 8'h00, 1'b1, 8'h00,
                  38'd0, 1, 1, 1'b0};
        tv[2] = '{1'b1, 6'd7,  32'h0000BEEF, 8'h00, 1'b1, 8'h02,
                  {6'd7, 32'h0000BEEF}, 2, 1, 1'b0};
        tv[3] = '{1'b1, 6'd3,  32'h0000CAFE, 8'h04, 1'b1, 8'h04,
                  {6'd3, 32'h0000CAFE}, 3, 1, 1'b0};
        tv[4] = '{1'b0, 6'd0,  32'h0,        8'h01, 1'b1, 8'h00,
                  38'd0, 3, 1, 1'b0};
        tv[5] = '{1'b0, 6'd0,  32'h0,        8'h01, 1'b1, 8'h00,
                  38'd0, 3, 1, 1'b1};
        tv[6] = '{1'b1, 6'd31, 32'hFFFFFFFF, 8'h00, 1'b1, 8'h08,
                  {6'd31, 32'hFFFFFFFF}, 4, 1, 1'b1};
        tv[7] = '{1'b1, 6'd32, 32'h11111111, 8'h00, 1'b1, 8'h00,
                  38'd0, 4, 2, 1'b1};
        tv[8] = '{1'b0, 6'd9,  32'h22222222, 8'h00, 1'b1, 8'h00,
                  38'd0, 4, 2, 1'b1};

        #12;
        chk("rst_vc",    64'(vc_target),  64'h0);
        chk("rst_pkt",   64'(packet),     64'h0);
        chk("rst_sent",  64'(sent_count), 64'h0);
        chk("rst_drop",  64'(drop_count), 64'h0);
        chk("rst_err",   64'(credit_err), 64'h0);
        chk("rst_ready", 64'(in_ready),   64'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            drive(tv[i].v, tv[i].d, tv[i].data, tv[i].gnt);
            chk($sformatf("tv%0d_ready", i), 64'(in_ready), 64'(tv[i].rdy));
            step();
            chk($sformatf("tv%0d_vc", i),   64'(vc_target),  64'(tv[i].vc));
            chk($sformatf("tv%0d_pkt", i),  64'(packet),     64'(tv[i].pkt));
            chk($sformatf("tv%0d_sent", i), 64'(sent_count), 64'(tv[i].sent));
            chk($sformatf("tv%0d_drop", i), 64'(drop_count), 64'(tv[i].drop));
            chk($sformatf("tv%0d_err", i),  64'(credit_err), 64'(tv[i].err));
        end

        // Exhaust every credit with a back-to-back burst.
        do_reset();
        for (int i = 0; i < 24; i++) begin
            drive(1'b1, A_W'(i), D_W'(i * 3), '0);
            chk($sformatf("burst%0d_ready", i), 64'(in_ready), 64'h1);
            step();
            chk($sformatf("burst%0d_vc", i), 64'(vc_target),
                64'(1 << (i % VC_W)));
        end
        chk("exh_ready", 64'(in_ready), 64'h0);
        drive(1'b1, 6'd20, 32'h0BADF00D, '0);
        step();
        chk("exh_vc",   64'(vc_target),  64'h0);
        chk("exh_sent", 64'(sent_count), 64'd24);
        drive(1'b1, 6'd20, 32'h0BADF00D, 8'h10);
        step();
        drive(1'b1, 6'd20, 32'h0BADF00D, 8'h00);
        chk("gnt_vc",    64'(vc_target), 64'h0);
        chk("gnt_ready", 64'(in_ready),  64'h1);
        step();
        chk("resume_vc",  64'(vc_target), 64'h10);
        chk("resume_pkt", 64'(packet), 64'({6'd20, 32'h0BADF00D}));
        chk("resume_ready", 64'(in_ready), 64'h0);
        chk("resume_sent", 64'(sent_count), 64'd25);

        // Asynchronous reset in the middle of a burst.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 6'd1, 32'h5, '0);
            step();
        end
        chk("pre_arst_vc", 64'(vc_target), 64'h04);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_vc",   64'(vc_target),  64'h0);
        chk("arst_pkt",  64'(packet),     64'h0);
        chk("arst_sent", 64'(sent_count), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_reset();
        chk("post_arst_ready", 64'(in_ready), 64'h1);
        drive(1'b1, 6'd9, 32'h77, '0);
        step();
        chk("post_arst_vc", 64'(vc_target), 64'h01);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic            rv;
            logic [A_W-1:0]  rd;
            logic [D_W-1:0]  rdat;
            logic [VC_W-1:0] rg;
            rv   = ($urandom_range(0, 3) != 0);
            rd   = A_W'($urandom_range(0, 39));
            rdat = $urandom;
            rg   = VC_W'($urandom & $urandom & $urandom);
            drive(rv, rd, rdat, rg);
            chk("rnd_ready", 64'(in_ready), 64'(m_ready()));
            m_step(rv, rd, rdat, rg);
            step();
            chk("rnd_vc",   64'(vc_target),  64'(m_vc));
            chk("rnd_pkt",  64'(packet),     64'(m_pkt));
            chk("rnd_sent", 64'(sent_count), 64'(m_sent));
            chk("rnd_drop", 64'(drop_count), 64'(m_drop));
            chk("rnd_err",  64'(credit_err), 64'(m_err));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
